axil_ram_responder: RTL and testbench

AXIL_RAM_RESPONDER -- requirements
Module: axil_ram_responder

---
 rtl/axil_pkg.sv | 29 ++
 rtl/axil_ram_bytewe.sv | 47 ++++
 rtl/axil_ram_responder.sv | 172 +++++++++++++++++
 tb/tb_axil_ram_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite RAM responder:
//   - AXI response codes (OKAY / SLVERR)
//   - write and read channel FSM state types
//   - address range helper used by both channels
// ---------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // A byte address is valid when it falls inside 4 * 2**depth_log2 bytes,
    // i.e. every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int depth_log2);
        return (addr >> (depth_log2 + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/axil_ram_bytewe.sv
// ---------------------------------------------------------------------------
// axil_ram_bytewe
// Simple dual-port RAM of 32-bit words with four byte-lane write enables and
// a registered (synchronous) read port, written so it maps onto block RAM.
// Ports:
//   clk    - clock
//   we     - per-byte write enables (lane i covers bits 8i+7:8i)
//   waddr  - write word index
//   wdata  - write data
//   re     - read enable; rdata keeps its value when re is low
//   raddr  - read word index
//   rdata  - registered read data
// A read and a write to the same word on the same edge returns the old word.
// ---------------------------------------------------------------------------
module axil_ram_bytewe
    import axil_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Separate read process: the non-blocking write above is not yet visible,
    // which gives read-first behaviour on a same-word collision.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axil_ram_responder.sv
// ---------------------------------------------------------------------------
// axil_ram_responder
// AXI4-Lite slave backed by a 2**DEPTH_LOG2 x 32-bit byte-writable RAM.
// Write and read channels are independent FSMs; at most one write and one
// read are in flight. Out-of-range accesses return SLVERR without touching
// memory (reads return zero data).
// Ports:
//   clk, rstn              - clock, synchronous active-low reset
//   s_axi_aw*              - write address channel
//   s_axi_w*               - write data channel (with byte strobes)
//   s_axi_b*               - write response channel
//   s_axi_ar*              - read address channel
//   s_axi_r*               - read data channel
// ---------------------------------------------------------------------------
module axil_ram_responder
    import axil_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    wr_state_t   wr_state;
    rd_state_t   rd_state;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_held;
    logic        w_held;
    logic        rdata_ok;
    logic [31:0] ram_q;

    logic        aw_fire;
    logic        w_fire;
    logic        ar_fire;
    logic        aw_ok;
    logic        ar_ok;
    logic        commit;

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign ar_fire = rstn && (rd_state == R_IDLE) && s_axi_arvalid && s_axi_arready;
    assign aw_ok   = addr_in_range(aw_addr_q, DEPTH_LOG2);
    assign ar_ok   = addr_in_range(s_axi_araddr, DEPTH_LOG2);

    // The write lands in memory on the edge after both halves are held, so the
    // RAM write port is fed purely from registers.
    assign commit  = rstn && (wr_state == W_IDLE) && aw_held && w_held;

    axil_ram_bytewe #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    ((commit && aw_ok) ? w_strb_q : 4'b0000),
        .waddr (aw_addr_q[DEPTH_LOG2+1:2]),
        .wdata (w_data_q),
        .re    (ar_fire && ar_ok),
        .raddr (s_axi_araddr[DEPTH_LOG2+1:2]),
        .rdata (ram_q)
    );

    // Out-of-range reads and reset force the data bus to zero.
    assign s_axi_rdata = rdata_ok ? ram_q : 32'd0;

    // Captured AW/W payloads; validity is tracked by the held flags.
    always_ff @(posedge clk) begin
        if (aw_fire) begin
            aw_addr_q <= s_axi_awaddr;
        end
        if (w_fire) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

    // Write channel FSM. Readies are registered so they are low in reset and
    // rise on the first clock after reset is released.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_state      <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_held && w_held) begin
                        aw_held      <= 1'b0;
                        w_held       <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                        wr_state     <= W_RESP;
                    end else begin
                        if (aw_fire) begin
                            aw_held <= 1'b1;
                        end
                        if (w_fire) begin
                            w_held <= 1'b1;
                        end
                        s_axi_awready <= !(aw_held || aw_fire);
                        s_axi_wready  <= !(w_held || w_fire);
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wr_state      <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM. The RAM captures the word on the AR handshake edge;
    // rdata_ok remembers whether that word is valid to present.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_state      <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            rdata_ok      <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rresp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        rdata_ok      <= ar_ok;
                        rd_state      <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state      <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_axil_ram_responder
// Self-checking bench for axil_ram_responder (DEPTH_LOG2 = 8). A byte-level
// reference memory with per-byte "known" flags supplies expected read data;
// bytes never written are not compared.
// ---------------------------------------------------------------------------
module tb_axil_ram_responder;

    localparam int          DEPTH_LOG2 = 8;
    localparam int          WORDS      = 2**DEPTH_LOG2;
    localparam logic [31:0] LIMIT      = 32'(4 * WORDS);

    logic        clk;
    logic        rstn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vectors;
    int miscompares;

    logic [31:0] model_mem   [WORDS];
    logic [3:0]  model_known [WORDS];

    axil_ram_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] expResp(input logic [31:0] addr);
        return (addr < LIMIT) ? 2'b00 : 2'b10;
    endfunction

    task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        if (addr < LIMIT) begin
            idx = int'(addr[DEPTH_LOG2+1:2]);
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) begin
                    model_mem[idx][i*8 +: 8] = data[i*8 +: 8];
                    model_known[idx][i]      = 1'b1;
                end
            end
        end
    endtask

    task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int          idx;
        logic [31:0] mask;
        checkOutput({tag, "_rresp"}, 32'(resp), 32'(expResp(addr)));
        if (addr < LIMIT) begin
            idx = int'(addr[DEPTH_LOG2+1:2]);
            for (int i = 0; i < 4; i++) begin
                mask[i*8 +: 8] = {8{model_known[idx][i]}};
            end
            checkOutput({tag, "_rdata"}, data & mask, model_mem[idx] & mask);
        end else begin
            checkOutput({tag, "_rdata"}, data, 32'd0);
        end
    endtask

    // Full write transaction. skew > 0 presents W that many cycles before AW,
    // skew < 0 presents AW first. bready rises bready_delay cycles after bvalid.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int skew, input int bready_delay, output logic [1:0] resp);
        int   aw_at;
        int   w_at;
        int   c;
        int   bseen;
        logic aw_done;
        logic w_done;
        logic b_done;
        logic aw_hs;
        logic w_hs;
        logic b_hs;
        aw_at   = (skew > 0) ? skew : 0;
        w_at    = (skew < 0) ? -skew : 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        bready  = 1'b0;
        c       = 0;
        bseen   = 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        b_done  = 1'b0;
        resp    = 2'bxx;
        while (!b_done && c < 60) begin
            if (!aw_done && c == aw_at) awvalid = 1'b1;
            if (!w_done && c == w_at) wvalid = 1'b1;
            checkOutput("b_before_aw_w", 32'(bvalid && !(aw_done && w_done)), 32'd0);
            if (bvalid) begin
                if (bseen == 0) resp = bresp;
                else checkOutput("bresp_stable", 32'(bresp), 32'(resp));
                if (bseen >= bready_delay) bready = 1'b1;
                bseen++;
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            step();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            if (b_hs)  begin bready  = 1'b0; b_done  = 1'b1; end
            if (w_done && !aw_done) checkOutput("wready_low_while_held", 32'(wready), 32'd0);
            if (aw_done && !w_done) checkOutput("awready_low_while_held", 32'(awready), 32'd0);
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        checkOutput("write_completed", 32'(b_done), 32'd1);
        checkOutput("bvalid_drop", 32'(bvalid), 32'd0);
        checkOutput("awready_after_b", 32'(awready), 32'd1);
        checkOutput("wready_after_b", 32'(wready), 32'd1);
    endtask

    // Full read transaction; rready is held low for rready_delay cycles.
    task automatic readTxn(input logic [31:0] addr, input int rready_delay,
                           output logic [31:0] data, output logic [1:0] resp);
        int   c;
        logic ar_done;
        logic ar_hs;
        araddr  = addr;
        arvalid = 1'b1;
        c       = 0;
        ar_done = 1'b0;
        while (!ar_done && c < 20) begin
            ar_hs = arvalid && arready;
            step();
            if (ar_hs) begin arvalid = 1'b0; ar_done = 1'b1; end
            c++;
        end
        arvalid = 1'b0;
        checkOutput("ar_accepted", 32'(ar_done), 32'd1);
        checkOutput("rvalid_latency", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        for (int k = 0; k < rready_delay; k++) begin
            step();
            checkOutput("rvalid_hold", 32'(rvalid), 32'd1);
            checkOutput("rdata_hold", rdata, data);
            checkOutput("rresp_hold", 32'(rresp), 32'(resp));
            checkOutput("arready_busy", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        checkOutput("rvalid_drop", 32'(rvalid), 32'd0);
        checkOutput("arready_back", 32'(arready), 32'd1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] old_word;
        logic [31:0] pool [6];
        int          c;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < WORDS; i++) begin
            model_mem[i]   = 32'd0;
            model_known[i] = 4'b0000;
        end
        rstn    = 1'b0;
        awaddr  = 32'd0;
        awvalid = 1'b0;
        wdata   = 32'd0;
        wstrb   = 4'b0000;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = 32'd0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset values
        repeat (3) step();
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_wready", 32'(wready), 32'd0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst_bresp", 32'(bresp), 32'd0);
        checkOutput("rst_arready", 32'(arready), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_rresp", 32'(rresp), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        rstn = 1'b1;
        step();
        checkOutput("post_rst_awready", 32'(awready), 32'd1);
        checkOutput("post_rst_wready", 32'(wready), 32'd1);
        checkOutput("post_rst_arready", 32'(arready), 32'd1);

        // Partial strobe write with AW and W together
        applyStimulus(32'h20, 32'hAAAAAAAA, 4'b1111, 0, 0, resp);
        checkOutput("w20_full_bresp", 32'(resp), 32'd0);
        modelWrite(32'h20, 32'hAAAAAAAA, 4'b1111);
        applyStimulus(32'h20, 32'h11111111, 4'b0011, 0, 0, resp);
        checkOutput("w20_strb_bresp", 32'(resp), 32'd0);
        modelWrite(32'h20, 32'h11111111, 4'b0011);
        readTxn(32'h20, 0, data, resp);
        checkOutput("r20_value", data, 32'hAAAA1111);
        checkRead("r20", 32'h20, data, resp);

        // W ahead of AW by three cycles, then AW ahead of W, slow bready
        applyStimulus(32'h24, 32'h0BADBEEF, 4'b1111, 3, 0, resp);
        checkOutput("w24_bresp", 32'(resp), 32'd0);
        modelWrite(32'h24, 32'h0BADBEEF, 4'b1111);
        readTxn(32'h27, 0, data, resp);
        checkOutput("r24_value", data, 32'h0BADBEEF);
        applyStimulus(32'h28, 32'hC0DE0001, 4'b1001, -2, 3, resp);
        checkOutput("w28_bresp", 32'(resp), 32'd0);
        modelWrite(32'h28, 32'hC0DE0001, 4'b1001);
        readTxn(32'h28, 0, data, resp);
        checkRead("r28", 32'h28, data, resp);

        // Read held off by rready for five cycles
        readTxn(32'h20, 5, data, resp);
        checkOutput("r20_slow_value", data, 32'hAAAA1111);
        checkOutput("r20_slow_rresp", 32'(resp), 32'd0);

        // Out-of-range accesses; 0x400 aliases word 0 in the low bits
        applyStimulus(32'h0, 32'h5A5A5A5A, 4'b1111, 0, 0, resp);
        modelWrite(32'h0, 32'h5A5A5A5A, 4'b1111);
        applyStimulus(32'h400, 32'hFFFFFFFF, 4'b1111, 0, 0, resp);
        checkOutput("w400_bresp", 32'(resp), 32'h2);
        readTxn(32'h400, 0, data, resp);
        checkOutput("r400_rresp", 32'(resp), 32'h2);
        checkOutput("r400_rdata", data, 32'd0);
        readTxn(32'h0, 0, data, resp);
        checkOutput("r0_untouched", data, 32'h5A5A5A5A);
        readTxn(32'h20, 0, data, resp);
        checkOutput("r20_untouched", data, 32'hAAAA1111);

        // Read and write to 0x40 on the same edge. The write commits on the
        // edge after AW/W are captured, so AR is issued one cycle after AW/W.
        applyStimulus(32'h40, 32'h12345678, 4'b1111, 0, 0, resp);
        modelWrite(32'h40, 32'h12345678, 4'b1111);
        old_word = 32'h12345678;
        awaddr  = 32'h40;
        wdata   = 32'hCAFEF00D;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        checkOutput("coll_awready", 32'(awready), 32'd1);
        checkOutput("coll_wready", 32'(wready), 32'd1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 32'h40;
        arvalid = 1'b1;
        checkOutput("coll_arready", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        checkOutput("coll_bvalid", 32'(bvalid), 32'd1);
        checkOutput("coll_rvalid", 32'(rvalid), 32'd1);
        checkOutput("coll_old_data", rdata, old_word);
        checkOutput("coll_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        rready = 1'b1;
        step();
        bready = 1'b0;
        rready = 1'b0;
        modelWrite(32'h40, 32'hCAFEF00D, 4'b1111);
        readTxn(32'h40, 0, data, resp);
        checkOutput("coll_new_data", data, 32'hCAFEF00D);

        // Reset while the write response is pending
        awaddr  = 32'h80;
        wdata   = 32'h600DCAFE;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        c = 0;
        while (!bvalid && c < 10) begin
            step();
            c++;
        end
        checkOutput("pend_bvalid", 32'(bvalid), 32'd1);
        modelWrite(32'h80, 32'h600DCAFE, 4'b1111);
        rstn = 1'b0;
        step();
        checkOutput("midrst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("midrst_awready", 32'(awready), 32'd0);
        checkOutput("midrst_wready", 32'(wready), 32'd0);
        checkOutput("midrst_arready", 32'(arready), 32'd0);
        checkOutput("midrst_rdata", rdata, 32'd0);
        step();
        rstn = 1'b1;
        step();
        checkOutput("rerst_awready", 32'(awready), 32'd1);
        checkOutput("rerst_bvalid", 32'(bvalid), 32'd0);
        applyStimulus(32'h80, 32'h00FF00FF, 4'b0101, 1, 1, resp);
        checkOutput("rerst_bresp", 32'(resp), 32'd0);
        modelWrite(32'h80, 32'h00FF00FF, 4'b0101);
        readTxn(32'h80, 0, data, resp);
        checkOutput("rerst_value", data, 32'h60FFCAFF);

        // Randomized mix against the reference memory
        for (int i = 0; i < 6; i++) begin
            pool[i] = 32'($urandom_range(0, WORDS - 1)) << 2;
        end
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if (a < LIMIT) a = a | 32'h8000_0000;
            end else begin
                a = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                applyStimulus(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                              int'($urandom_range(0, 2)), resp);
                checkOutput("rand_bresp", 32'(resp), 32'(expResp(a)));
                modelWrite(a, d, wstrb);
            end else begin
                readTxn(a, int'($urandom_range(0, 2)), data, resp);
                checkRead("rand_read", a, data, resp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
